uart_rx_ext: RTL

- Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width (5-9), parity (none/even/odd), 1 or 2 stop bits and oversample factor.
- Adds input synchronisation, per-frame parity/framing/break flags, a ready/valid output handshake and sticky overrun detection.
- Sits between the RX pin and a byte FIFO or register-file consumer.

---
 rtl/uart_rx_ext.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with configurable framing and parity.
// Frames go out through a one-deep ready/valid slot that raises a sticky overrun flag when full.
`timescale 1ns/1ps
module uart_rx_ext #(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned DivRaw = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned TickW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
  localparam logic             OddPar   = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [TickW-1:0]     tcnt_q, tcnt_d;
  logic [BitW-1:0]      bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 done_q, done_d;
  logic [1:0]           sync_q;
  logic [1:0]           samp_q;
  logic                 tick, line, maj, brk_now;

  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, ovr_q, ovr_d;

  assign line = sync_q[1];
  // Two stored samples plus the live one form the 3-sample majority window.
  assign maj  = (samp_q[1] & samp_q[0]) | (samp_q[1] & line) | (samp_q[0] & line);
  assign tick = en && (div_q == DivLast);

  always_comb begin
    div_d = div_q;
    if (!en || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    brk_now = (bcnt_q == '0) ? (zero_q & ~maj) : zero_q;
    if (!en) begin
      state_d = StIdle;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!line) begin
            state_d = StStart;
            tcnt_d  = '0;
          end
        end
        StStart: begin
          if (tcnt_q == HalfLast) begin
            tcnt_d = '0;
            bcnt_d = '0;
            if (!maj) begin
              state_d = StData;
              data_d  = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              zero_d  = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StData: begin
          if (tcnt_q == FullLast) begin
            tcnt_d = '0;
            data_d = {maj, data_q[DATA_BITS-1:1]};
            zero_d = zero_q & ~maj;
            if (bcnt_q == DataLast) begin
              bcnt_d  = '0;
              state_d = (PARITY != 0) ? StParity : StStop;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StParity: begin
          if (tcnt_q == FullLast) begin
            tcnt_d  = '0;
            perr_d  = (^data_q) ^ maj ^ OddPar;
            zero_d  = zero_q & ~maj;
            state_d = StStop;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tcnt_q == FullLast) begin
            tcnt_d = '0;
            ferr_d = ferr_q | ~maj;
            if (bcnt_q == '0) begin
              zero_d = zero_q & ~maj;
            end
            if (bcnt_q == StopLast) begin
              bcnt_d  = '0;
              done_d  = 1'b1;
              state_d = brk_now ? StBrk : StIdle;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StBrk: begin
          if (maj) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output slot: accept and load may coincide; a full slot drops the new frame.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || ready) begin
        out_d   = data_q;
        pe_d    = perr_q;
        fe_d    = ferr_q;
        brk_d   = zero_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 2'b11;
      samp_q  <= 2'b11;
      out_q   <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      sync_q  <= {sync_q[0], in};
      if (tick) begin
        samp_q <= {samp_q[0], line};
      end
      out_q   <= out_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out        = out_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;

endmodule
